// File: rtl/mult_pkg.sv
// Shared types and default sizing for the mult_acc accumulation stage.
package mult_pkg;

    localparam int PROD_W         = 16;
    localparam int ACC_W_DEF      = 20;
    localparam int N_TERMS_DEF    = 4;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/mult_acc_if.sv
// Product-in / result-out bus of mult_acc; master drives products and control.
interface mult_acc_if import mult_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF
);

    logic             activate;
    logic             clear;
    logic             prod_valid;
    logic [7:0]       prod_lo;
    logic [7:0]       prod_hi;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             overflow;
    logic [7:0]       term_cnt;

    modport master (
        output activate, clear, prod_valid, prod_lo, prod_hi, acc_ready,
        input  prod_ready, acc_out, acc_valid, overflow, term_cnt
    );

    modport slave (
        input  activate, clear, prod_valid, prod_lo, prod_hi, acc_ready,
        output prod_ready, acc_out, acc_valid, overflow, term_cnt
    );

endinterface

// File: rtl/mult_acc_fifo.sv
// Small synchronous FIFO buffering products ahead of the accumulator.
module mult_acc_fifo import mult_pkg::*; #(
    parameter int WIDTH = PROD_W,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q && !flush;
    assign do_pop  = pop && !empty_q && !flush;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    // NOTE: storage is not reset; the pointers and flags alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/mult_acc.sv
// Sums N_TERMS 16-bit products into an ACC_W accumulator with valid/ready output.
// Define MULT_ACC_SAT_EN to saturate on carry-out instead of wrapping.
module mult_acc import mult_pkg::*; #(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int N_TERMS    = N_TERMS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic     clk,
    input  logic     reset,
    mult_acc_if.slave bus
);

    localparam logic [7:0] N_LAST = 8'(N_TERMS);

    state_t            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [7:0]        cnt_q;
    logic              ovf_q;
    logic              valid_q;

    logic [PROD_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ACC_W:0]    sum_d;
    logic [ACC_W-1:0]  acc_add_d;

    assign push = bus.prod_valid && bus.prod_ready;
    assign pop  = (state_q == ACCUM) && bus.activate && !fifo_empty && !bus.clear;

    mult_acc_fifo #(
        .WIDTH (PROD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.clear),
        .push  (push),
        .pop   (pop),
        .din   ({bus.prod_hi, bus.prod_lo}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        sum_d = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, fifo_dout};
`ifdef MULT_ACC_SAT_EN
        acc_add_d = sum_d[ACC_W] ? '1 : sum_d[ACC_W-1:0];
`else
        acc_add_d = sum_d[ACC_W-1:0];
`endif
    end

    // Clear outranks everything but reset; a result completes on the edge of its last add.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.activate) state_q <= ACCUM;
                end
                ACCUM: begin
                    if (pop) begin
                        acc_q <= acc_add_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (sum_d[ACC_W]) ovf_q <= 1'b1;
                        if (cnt_q + 1'b1 == N_LAST) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= bus.activate ? ACCUM : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.prod_ready = !fifo_full;
    assign bus.acc_out    = acc_q;
    assign bus.acc_valid  = valid_q;
    assign bus.overflow   = ovf_q;
    assign bus.term_cnt   = cnt_q;

endmodule

// File: tb/tb_mult_acc.sv
// Self-checking bench for mult_acc: directed vectors, corner sequences and a random run vs. a queue model.
module tb_mult_acc;

    localparam int ACC_W = 20;
    localparam int N_A   = 4;
    localparam int N_B   = 17;

    typedef struct packed {
        logic [3:0][15:0] p;
        logic [19:0]      sum;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_acc_if #(.ACC_W(ACC_W)) bus_a ();
    mult_acc_if #(.ACC_W(ACC_W)) bus_b ();

    mult_acc #(.ACC_W(ACC_W), .N_TERMS(N_A), .FIFO_DEPTH(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mult_acc #(.ACC_W(ACC_W), .N_TERMS(N_B), .FIFO_DEPTH(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [4];
    logic [15:0] model_q [$];
    longint      exp_sum;
    longint      exp_b;
    bit          holding;
    bit          rdy;
    int          results;
    int          n_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one product to dut_a and hold it until it is taken (bounded).
    task automatic push_a(input logic [15:0] p);
        bit done;
        done = 1'b0;
        bus_a.prod_hi    = p[15:8];
        bus_a.prod_lo    = p[7:0];
        bus_a.prod_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            done = bus_a.prod_ready;
            tick();
        end
        bus_a.prod_valid = 1'b0;
        check("push_accepted", 32'(done), 1);
    endtask

    task automatic wait_valid_a(input int max_edges);
        for (int k = 0; k < max_edges && !bus_a.acc_valid; k++) tick();
        check("acc_valid_arrives", 32'(bus_a.acc_valid), 1);
    endtask

    task automatic handshake_a();
        bus_a.acc_ready = 1'b1;
        tick();
        bus_a.acc_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{p: {16'h0100, 16'h00FF, 16'h0001, 16'h1234}, sum: 20'h01434};
        vecs[1] = '{p: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, sum: 20'h3FFFC};
        vecs[2] = '{p: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, sum: 20'h00000};
        vecs[3] = '{p: {16'h0002, 16'h7FFF, 16'h0001, 16'h8000}, sum: 20'h10002};

        reset = 1'b1;
        bus_a.activate = 0; bus_a.clear = 0; bus_a.prod_valid = 0;
        bus_a.prod_lo = 0;  bus_a.prod_hi = 0; bus_a.acc_ready = 0;
        bus_b.activate = 0; bus_b.clear = 0; bus_b.prod_valid = 0;
        bus_b.prod_lo = 0;  bus_b.prod_hi = 0; bus_b.acc_ready = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset values
        check("rst_acc_out",    32'(bus_a.acc_out),    0);
        check("rst_acc_valid",  32'(bus_a.acc_valid),  0);
        check("rst_overflow",   32'(bus_a.overflow),   0);
        check("rst_term_cnt",   32'(bus_a.term_cnt),   0);
        check("rst_prod_ready", 32'(bus_a.prod_ready), 1);

        // Directed sums on consecutive cycles; valid must rise 2 edges after the last push
        bus_a.activate = 1'b1;
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) push_a(vecs[v].p[i]);
            check("vec_valid_not_early", 32'(bus_a.acc_valid), 0);
            tick();
            check("vec_valid_2_edges", 32'(bus_a.acc_valid), 1);
            check("vec_sum",           32'(bus_a.acc_out),   32'(vecs[v].sum));
            check("vec_term_cnt",      32'(bus_a.term_cnt),  N_A);
            check("vec_overflow",      32'(bus_a.overflow),  0);
            handshake_a();
            check("vec_valid_drop",    32'(bus_a.acc_valid), 0);
            check("vec_cnt_zero",      32'(bus_a.term_cnt),  0);
            check("vec_acc_zero",      32'(bus_a.acc_out),   0);
        end

        // Back-pressure while the result waits in HOLD
        push_a(16'h0001); push_a(16'h0002); push_a(16'h0003); push_a(16'h0004);
        wait_valid_a(5);
        check("bp_hold_sum", 32'(bus_a.acc_out), 32'h0A);
        push_a(16'h0010);
        push_a(16'h0020);
        check("bp_full_ready", 32'(bus_a.prod_ready), 0);
        bus_a.prod_hi = 8'h00; bus_a.prod_lo = 8'h30; bus_a.prod_valid = 1'b1;
        repeat (3) tick();
        check("bp_ready_held_low", 32'(bus_a.prod_ready), 0);
        check("bp_acc_frozen",     32'(bus_a.acc_out),    32'h0A);
        check("bp_valid_held",     32'(bus_a.acc_valid),  1);
        handshake_a();
        check("bp_released", 32'(bus_a.acc_valid), 0);
        push_a(16'h0030);
        push_a(16'h0040);
        wait_valid_a(10);
        check("bp_next_sum", 32'(bus_a.acc_out), 32'hA0);
        handshake_a();

        // Pause after two terms
        push_a(16'h0101); push_a(16'h0202);
        for (int k = 0; k < 10 && bus_a.term_cnt != 8'd2; k++) tick();
        check("pause_cnt_reached", 32'(bus_a.term_cnt), 2);
        bus_a.activate = 1'b0;
        push_a(16'h0303); push_a(16'h0404);
        check("pause_fifo_full", 32'(bus_a.prod_ready), 0);
        repeat (3) tick();
        check("pause_cnt_held",  32'(bus_a.term_cnt),  2);
        check("pause_no_valid",  32'(bus_a.acc_valid), 0);
        bus_a.activate = 1'b1;
        wait_valid_a(10);
        check("pause_sum", 32'(bus_a.acc_out),  32'h0A0A);
        check("pause_cnt", 32'(bus_a.term_cnt), N_A);
        handshake_a();

        // Clear at term_cnt=3 with one product buffered and a simultaneous push
        push_a(16'h0011); push_a(16'h0022); push_a(16'h0033);
        for (int k = 0; k < 10 && bus_a.term_cnt != 8'd3; k++) tick();
        check("clr_cnt_reached", 32'(bus_a.term_cnt), 3);
        bus_a.activate = 1'b0;
        push_a(16'h0044);
        bus_a.clear = 1'b1;
        bus_a.prod_hi = 8'h77; bus_a.prod_lo = 8'h77; bus_a.prod_valid = 1'b1;
        tick();
        bus_a.clear = 1'b0;
        bus_a.prod_valid = 1'b0;
        check("clr_acc_out",    32'(bus_a.acc_out),    0);
        check("clr_term_cnt",   32'(bus_a.term_cnt),   0);
        check("clr_acc_valid",  32'(bus_a.acc_valid),  0);
        check("clr_overflow",   32'(bus_a.overflow),   0);
        check("clr_prod_ready", 32'(bus_a.prod_ready), 1);
        bus_a.activate = 1'b1;
        repeat (4) tick();
        check("clr_fifo_empty", 32'(bus_a.term_cnt), 0);
        push_a(16'h0005); push_a(16'h0005); push_a(16'h0005); push_a(16'h0005);
        wait_valid_a(5);
        check("clr_next_sum", 32'(bus_a.acc_out), 32'h14);
        handshake_a();

        // Asynchronous reset between edges with a partial sum and a full FIFO
        push_a(16'h0100);
        for (int k = 0; k < 10 && bus_a.term_cnt != 8'd1; k++) tick();
        bus_a.activate = 1'b0;
        push_a(16'h0001); push_a(16'h0002);
        check("ar_pre_full", 32'(bus_a.prod_ready), 0);
        #2 reset = 1'b1;
        #1;
        check("ar_acc_out",    32'(bus_a.acc_out),    0);
        check("ar_term_cnt",   32'(bus_a.term_cnt),   0);
        check("ar_acc_valid",  32'(bus_a.acc_valid),  0);
        check("ar_overflow",   32'(bus_a.overflow),   0);
        check("ar_prod_ready", 32'(bus_a.prod_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        bus_a.activate = 1'b1;
        repeat (4) tick();
        check("ar_fifo_empty", 32'(bus_a.term_cnt), 0);

        // Overflow on the 17-term instance
        exp_sum = 0;
        for (int i = 0; i < N_B; i++) exp_sum += 64'hFFFF;
`ifdef MULT_ACC_SAT_EN
        exp_b = (exp_sum >= (64'd1 << ACC_W)) ? ((64'd1 << ACC_W) - 1) : exp_sum;
`else
        exp_b = exp_sum % (64'd1 << ACC_W);
`endif
        bus_b.activate = 1'b1;
        bus_b.prod_hi = 8'hFF; bus_b.prod_lo = 8'hFF;
        n_acc = 0;
        for (int k = 0; k < 200 && n_acc < N_B; k++) begin
            bus_b.prod_valid = 1'b1;
            rdy = bus_b.prod_ready;
            tick();
            if (rdy) n_acc++;
        end
        bus_b.prod_valid = 1'b0;
        check("ovf_pushes", 32'(n_acc), N_B);
        for (int k = 0; k < 10 && !bus_b.acc_valid; k++) tick();
        check("ovf_valid",    32'(bus_b.acc_valid), 1);
        check("ovf_acc_out",  32'(bus_b.acc_out),   32'(exp_b));
        check("ovf_flag",     32'(bus_b.overflow),  1);
        check("ovf_term_cnt", 32'(bus_b.term_cnt),  N_B);
        bus_b.acc_ready = 1'b1;
        tick();
        bus_b.acc_ready = 1'b0;
        check("ovf_flag_clr", 32'(bus_b.overflow), 0);
        check("ovf_acc_clr",  32'(bus_b.acc_out),  0);

        // Random traffic against a queue model: each result is the sum of the next N_A accepted products
        holding = 1'b0;
        results = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus_a.acc_ready = ($urandom_range(0, 3) != 0);
            if (bus_a.acc_valid && bus_a.acc_ready) begin
                check("rand_model_depth", 32'(model_q.size() >= N_A), 1);
                if (model_q.size() >= N_A) begin
                    exp_sum = 0;
                    for (int i = 0; i < N_A; i++) exp_sum += longint'(model_q.pop_front());
                    check("rand_sum", 32'(bus_a.acc_out), 32'(exp_sum % (64'd1 << ACC_W)));
                    check("rand_cnt", 32'(bus_a.term_cnt), N_A);
                    check("rand_ovf", 32'(bus_a.overflow), 0);
                    results++;
                end
            end
            if (!holding) begin
                bus_a.prod_valid = ($urandom_range(0, 9) < 6);
                {bus_a.prod_hi, bus_a.prod_lo} = 16'($urandom);
            end
            if (bus_a.prod_valid && bus_a.prod_ready) begin
                model_q.push_back({bus_a.prod_hi, bus_a.prod_lo});
                holding = 1'b0;
            end else begin
                holding = bus_a.prod_valid;
            end
            bus_a.activate = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus_a.prod_valid = 1'b0;
        bus_a.acc_ready  = 1'b0;
        check("rand_results_seen", 32'(results >= 20), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
